// File: rtl/entropy_collector_pkg.sv
// Shared types and constants for the TRNG entropy collector.
package entropy_collector_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StFull    = 2'd2,
    StError   = 2'd3
  } state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/entropy_collector_if.sv
// Source-side word handshake and mixer-side block handshake of the collector.
interface entropy_collector_if #(
  parameter int unsigned NUM_WORDS = 16
);
  import entropy_collector_pkg::*;

  logic [WORD_WIDTH-1:0]           entropy_data;
  logic                            entropy_valid;
  logic                            entropy_ack;
  logic [NUM_WORDS*WORD_WIDTH-1:0] block_data;
  logic                            block_valid;
  logic                            block_ack;

  // master: the collector; slave: the source/mixer environment around it.
  modport master (
    input  entropy_data, entropy_valid, block_ack,
    output entropy_ack, block_data, block_valid
  );

  modport slave (
    output entropy_data, entropy_valid, block_ack,
    input  entropy_ack, block_data, block_valid
  );

endinterface

// File: rtl/entropy_collector_rep_count_test.sv
// Repetition-count health test: flags REP_LIMIT consecutive identical accepted words.
module entropy_collector_rep_count_test
  import entropy_collector_pkg::*;
#(
  parameter int unsigned REP_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic                  i_strobe,
  input  logic                  i_restart,
  input  logic                  i_test_mode,
  output logic                  o_fail
);

  localparam logic [7:0] RepLim = 8'(REP_LIMIT);

  logic [7:0]            r_rep_ctr;
  logic [WORD_WIDTH-1:0] r_prev_word;
  logic                  r_first_flag;
  logic                  w_repeat;
  logic [7:0]            w_rep_next;

  // Count saturates at the limit so test mode never wraps it.
  always_comb begin
    w_repeat = !r_first_flag && (i_word == r_prev_word);
    if (!w_repeat) begin
      w_rep_next = 8'd1;
    end else if (r_rep_ctr == RepLim) begin
      w_rep_next = RepLim;
    end else begin
      w_rep_next = r_rep_ctr + 8'd1;
    end
  end

  assign o_fail = i_strobe && !i_test_mode && (w_rep_next == RepLim);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rep_ctr    <= 8'd0;
      r_prev_word  <= '0;
      r_first_flag <= 1'b1;
    end else if (i_restart) begin
      r_rep_ctr    <= 8'd0;
      r_first_flag <= 1'b1;
    end else if (i_strobe) begin
      r_rep_ctr    <= w_rep_next;
      r_prev_word  <= i_word;
      r_first_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Packs health-tested entropy words into NUM_WORDS-word blocks for the mixer.
module entropy_collector
  import entropy_collector_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned REP_LIMIT = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_test_mode,
  input  logic                i_clear_error,
  input  logic                i_entropy_enabled,
  entropy_collector_if.master io_bus,
  output logic                o_health_error,
  output logic [31:0]         o_word_count
);

  localparam int unsigned CtrW = cnt_width(NUM_WORDS);
  localparam int unsigned BlkW = NUM_WORDS * WORD_WIDTH;
  localparam logic [CtrW-1:0] LastCtr = CtrW'(NUM_WORDS - 1);

  state_e          r_state;
  logic            r_entropy_ack;
  logic            r_block_valid;
  logic            r_health_error;
  logic [BlkW-1:0] r_block_data;
  logic [31:0]     r_word_count;
  logic [CtrW-1:0] r_word_ctr;

  logic w_accept;
  logic w_fail;
  logic w_restart;

  // The !ack term keeps a held source word from being taken twice.
  assign w_accept = (r_state == StCollect) && i_enable && io_bus.entropy_valid &&
                    i_entropy_enabled && !r_entropy_ack;

  assign w_restart = (r_state == StIdle) || ((r_state == StCollect) && !i_enable) ||
                     ((r_state == StError) && i_clear_error);

  entropy_collector_rep_count_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep_test (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_word     (io_bus.entropy_data),
    .i_strobe   (w_accept),
    .i_restart  (w_restart),
    .i_test_mode(i_test_mode),
    .o_fail     (w_fail)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_entropy_ack  <= 1'b0;
      r_block_valid  <= 1'b0;
      r_health_error <= 1'b0;
      r_block_data   <= '0;
      r_word_count   <= 32'd0;
      r_word_ctr     <= '0;
    end else begin
      r_entropy_ack <= w_accept;
      case (r_state)
        StIdle: begin
          if (i_enable && i_entropy_enabled) r_state <= StCollect;
        end
        StCollect: begin
          if (!i_enable) begin
            r_state      <= StIdle;
            r_word_ctr   <= '0;
            r_block_data <= '0;
          end else if (w_accept) begin
            r_word_count <= r_word_count + 32'd1;
            if (w_fail) begin
              r_state        <= StError;
              r_health_error <= 1'b1;
              r_word_ctr     <= '0;
              r_block_data   <= '0;
            end else begin
              r_block_data <= {r_block_data[BlkW-WORD_WIDTH-1:0], io_bus.entropy_data};
              if (r_word_ctr == LastCtr) begin
                r_state       <= StFull;
                r_block_valid <= 1'b1;
                r_word_ctr    <= '0;
              end else begin
                r_word_ctr <= r_word_ctr + CtrW'(1);
              end
            end
          end
        end
        StFull: begin
          if (io_bus.block_ack) begin
            r_block_valid <= 1'b0;
            r_state       <= i_enable ? StCollect : StIdle;
          end
        end
        StError: begin
          if (i_clear_error) begin
            r_health_error <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.entropy_ack = r_entropy_ack;
  assign io_bus.block_valid = r_block_valid;
  assign io_bus.block_data  = r_block_data;
  assign o_health_error     = r_health_error;
  assign o_word_count       = r_word_count;

endmodule

// File: tb/tb_entropy_collector.sv
// Scoreboard bench for entropy_collector: directed sources, queued expected blocks.
module tb_entropy_collector;
  import entropy_collector_pkg::*;

  localparam int unsigned NW = 16;
  localparam int unsigned BW = NW * 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        test_mode;
  logic        clear_error;
  logic        ent_en;
  logic        health_error;
  logic [31:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  entropy_collector_if #(.NUM_WORDS(NW)) bus ();

  entropy_collector #(
    .NUM_WORDS(NW),
    .REP_LIMIT(8)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_enable         (enable),
    .i_test_mode      (test_mode),
    .i_clear_error    (clear_error),
    .i_entropy_enabled(ent_en),
    .io_bus           (bus),
    .o_health_error   (health_error),
    .o_word_count     (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_block(input logic [31:0] first, input bit incr);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < NW; i++) b = {b[BW-33:0], (incr ? first + 32'(i) : first)};
    return b;
  endfunction

  // Monitor: every new block is compared against the head of the scoreboard.
  logic prev_valid = 1'b0;
  logic prev_ack   = 1'b0;
  always @(negedge clk) begin
    if (bus.block_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %0h required no block", bus.block_data);
      end else begin
        chk("block_data", bus.block_data, exp_q.pop_front());
      end
    end
    if (bus.entropy_ack && prev_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_pulse: got ack high 2 cycles required 1 cycle");
    end
    prev_valid = bus.block_valid;
    prev_ack   = bus.entropy_ack;
  end

  task automatic send_words(input logic [31:0] first, input int n, input bit incr,
                            output int cycles);
    int waited;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      bus.entropy_data  = incr ? first + 32'(i) : first;
      bus.entropy_valid = 1'b1;
      waited = 0;
      do begin
        @(negedge clk);
        cycles++;
        waited++;
      end while (!bus.entropy_ack && waited < 20);
      if (!bus.entropy_ack) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: got no ack for word %0d required ack within 20 cycles", i);
        break;
      end
    end
    bus.entropy_valid = 1'b0;
  endtask

  task automatic wait_block(input int max);
    int n;
    n = 0;
    while (!bus.block_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.block_valid) begin
      errors++;
      $display("FAIL block_timeout: got block_valid=0 required 1 within %0d cycles", max);
    end
  endtask

  task automatic ack_block();
    bus.block_ack = 1'b1;
    @(negedge clk);
    bus.block_ack = 1'b0;
  endtask

  initial begin
    int cyc;
    int acks;
    int lat;
    logic [BW-1:0] exp_b;

    rst = 1'b0; enable = 1'b0; test_mode = 1'b1; clear_error = 1'b0; ent_en = 1'b1;
    bus.entropy_valid = 1'b0; bus.entropy_data = '0; bus.block_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ack", BW'(bus.entropy_ack), '0);
    chk("rst_block_valid", BW'(bus.block_valid), '0);
    chk("rst_block_data", bus.block_data, '0);
    chk("rst_health", BW'(health_error), '0);
    chk("rst_word_count", BW'(word_count), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fixed pattern with health test bypassed.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk_block(32'haa55aa55, 1'b0));
    send_words(32'haa55aa55, 16, 1'b0, cyc);
    chk("a_ack_spacing", BW'(cyc), BW'(31));
    wait_block(5);
    chk("a_word_count", BW'(word_count), BW'(16));
    repeat (3) @(negedge clk);
    chk("a_valid_held", BW'(bus.block_valid), BW'(1));
    ack_block();

    // Incrementing source with the health test live, then held block_ack.
    test_mode = 1'b0;
    exp_b = mk_block(32'h1, 1'b1);
    exp_q.push_back(exp_b);
    send_words(32'h1, 16, 1'b1, cyc);
    wait_block(5);
    chk("b_word_count", BW'(word_count), BW'(32));
    chk("b_health", BW'(health_error), '0);
    bus.entropy_data = 32'h11;
    bus.entropy_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("b_hold_data", bus.block_data, exp_b);
      chk("b_hold_noack", BW'(bus.entropy_ack), '0);
    end
    bus.block_ack = 1'b1;
    lat = 5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.block_ack = 1'b0;
      if (bus.entropy_ack) begin
        lat = k + 1;
        break;
      end
    end
    checks++;
    if (lat > 2) begin
      errors++;
      $display("FAIL b_resume: got %0d cycles required at most 2", lat);
    end
    bus.entropy_valid = 1'b0;

    // Drop enable after 5 accepts; partial block must vanish.
    send_words(32'h12, 4, 1'b1, cyc);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("c_word_count", BW'(word_count), BW'(37));
    chk("c_discard", bus.block_data, '0);
    chk("c_no_valid", BW'(bus.block_valid), '0);
    enable = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk_block(32'h100, 1'b1));
    send_words(32'h100, 16, 1'b1, cyc);
    wait_block(5);
    chk("c_word_count2", BW'(word_count), BW'(53));
    ack_block();

    // Stuck source trips the repetition test on the 8th accept.
    bus.entropy_data = 32'haa55aa55;
    bus.entropy_valid = 1'b1;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.entropy_ack) begin
        acks++;
        if (acks == 8) chk("d_err_8th", BW'(health_error), BW'(1));
        else chk("d_no_err_early", BW'(health_error), '0);
      end
    end
    chk("d_ack_total", BW'(acks), BW'(8));
    chk("d_word_count", BW'(word_count), BW'(61));
    chk("d_sticky", BW'(health_error), BW'(1));
    chk("d_data_zero", bus.block_data, '0);
    clear_error = 1'b1;
    test_mode = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("d_cleared", BW'(health_error), '0);
    exp_q.push_back(mk_block(32'haa55aa55, 1'b0));
    send_words(32'haa55aa55, 16, 1'b0, cyc);
    wait_block(5);
    chk("d_word_count2", BW'(word_count), BW'(77));
    ack_block();

    // Reset mid-collect and while a block is pending.
    send_words(32'hdead0001, 3, 1'b1, cyc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("e1_word_count", BW'(word_count), '0);
    chk("e1_block_data", bus.block_data, '0);
    chk("e1_ack", BW'(bus.entropy_ack), '0);
    chk("e1_valid", BW'(bus.block_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(mk_block(32'h5a5a0000, 1'b1));
    send_words(32'h5a5a0000, 16, 1'b1, cyc);
    wait_block(5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("e2_valid", BW'(bus.block_valid), '0);
    chk("e2_block_data", bus.block_data, '0);
    chk("e2_word_count", BW'(word_count), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("e_queue_empty", BW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before 100000 ns");
    $fatal(1, "watchdog");
  end

endmodule
